// File: rtl/multicycle_ctrl.sv
// Control FSM for a multi-cycle RV32I core sharing one memory port (ready handshake, timeout trap).
// Define MC_CTRL_JALR_EN to decode JALR; otherwise opcode 1100111 traps.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [2:0]  imm_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [1:0]  result_src,
    output logic [3:0]  state,
    output logic        trap,
    output logic        timeout
);

    // Debug encoding seen on the state port.
    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,  ST_DECODE  = 4'd1,  ST_MEMADR  = 4'd2,
        ST_MEMREAD = 4'd3,  ST_MEMWB   = 4'd4,  ST_MEMWRITE = 4'd5,
        ST_EXEC_R  = 4'd6,  ST_EXEC_I  = 4'd7,  ST_ALUWB   = 4'd8,
        ST_BEQ     = 4'd9,  ST_JAL     = 4'd10, ST_LUI     = 4'd11,
        ST_TRAP    = 4'd12, ST_JALR    = 4'd13, ST_JALR_PC = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
`ifdef MC_CTRL_JALR_EN
    localparam logic [6:0] OP_JALR  = 7'b1100111;
`endif

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    // Counter value seen in the last permitted wait cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_trap;
    logic             r_timeout;
    logic             w_to_hit;
    logic             w_timeout_trap;
    logic             w_wait;
    logic [6:0]       w_opc;
    logic             w_unused_inst;

    assign w_opc         = inst[6:0];
    assign w_unused_inst = ^inst[31:7];
    assign w_wait        = mem_req && !mem_ready;
    assign w_to_hit      = (MEM_TIMEOUT != 0) && !mem_ready && (r_cnt == CNT_LAST);

    // NOTE: state, counter and flags update with <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_cnt     <= '0;
            r_trap    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_wait)
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_next == ST_TRAP)
                r_trap <= 1'b1;
            if (w_timeout_trap)
                r_timeout <= 1'b1;
        end
    end

    // NOTE: every output gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        w_next         = r_state;
        w_timeout_trap = 1'b0;
        mem_req        = 1'b0;
        mem_write      = 1'b0;
        adr_src        = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        reg_write      = 1'b0;
        imm_src        = IMM_I;
        alu_src_a      = 2'd0;
        alu_src_b      = 2'd0;
        alu_op         = 3'd0;
        result_src     = 2'd0;
        if (rst_n) begin
            case (r_state)
                ST_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'd2;
                    result_src = 2'd2;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        w_next   = ST_DECODE;
                    end else if (w_to_hit) begin
                        w_next         = ST_TRAP;
                        w_timeout_trap = 1'b1;
                    end
                end
                ST_DECODE: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd1;
                    imm_src   = (w_opc == OP_JAL) ? IMM_J : IMM_B;
                    case (w_opc)
                        OP_LOAD, OP_STORE: w_next = ST_MEMADR;
                        OP_R:              w_next = ST_EXEC_R;
                        OP_I:              w_next = ST_EXEC_I;
                        OP_BR:             w_next = ST_BEQ;
                        OP_JAL:            w_next = ST_JAL;
                        OP_LUI:            w_next = ST_LUI;
`ifdef MC_CTRL_JALR_EN
                        OP_JALR:           w_next = ST_JALR;
`endif
                        default:           w_next = ST_TRAP;
                    endcase
                end
                ST_MEMADR: begin
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd1;
                    imm_src   = (w_opc == OP_STORE) ? IMM_S : IMM_I;
                    w_next    = (w_opc == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
                end
                ST_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) begin
                        w_next = ST_MEMWB;
                    end else if (w_to_hit) begin
                        w_next         = ST_TRAP;
                        w_timeout_trap = 1'b1;
                    end
                end
                ST_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = 2'd1;
                    w_next     = ST_FETCH;
                end
                ST_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    if (mem_ready) begin
                        w_next = ST_FETCH;
                    end else if (w_to_hit) begin
                        w_next         = ST_TRAP;
                        w_timeout_trap = 1'b1;
                    end
                end
                ST_EXEC_R: begin
                    alu_src_a = 2'd2;
                    alu_op    = 3'd2;
                    w_next    = ST_ALUWB;
                end
                ST_EXEC_I: begin
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd1;
                    alu_op    = 3'd3;
                    w_next    = ST_ALUWB;
                end
                ST_ALUWB: begin
                    reg_write = 1'b1;
                    w_next    = ST_FETCH;
                end
                ST_BEQ: begin
                    alu_src_a = 2'd2;
                    alu_op    = 3'd1;
                    pc_write  = zero;
                    w_next    = ST_FETCH;
                end
                ST_JAL: begin
                    pc_write  = 1'b1;
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    w_next    = ST_ALUWB;
                end
                ST_LUI: begin
                    imm_src    = IMM_U;
                    result_src = 2'd3;
                    reg_write  = 1'b1;
                    w_next     = ST_FETCH;
                end
                ST_TRAP: w_next = ST_TRAP;
`ifdef MC_CTRL_JALR_EN
                ST_JALR: begin
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd1;
                    w_next    = ST_JALR_PC;
                end
                ST_JALR_PC: begin
                    pc_write  = 1'b1;
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    w_next    = ST_ALUWB;
                end
`endif
                default: w_next = ST_TRAP;
            endcase
        end
    end

    assign state   = r_state;
    assign trap    = r_trap;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases plus random instructions against a phase-list model.
// Honours MC_CTRL_JALR_EN the same way the design does.
module tb_multicycle_ctrl;
    localparam int TO = 3;
    localparam int CW = 2;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3;
    localparam logic [3:0] S_MEMWB = 4'd4,  S_MEMWRITE = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7;
    localparam logic [3:0] S_ALUWB = 4'd8,  S_BEQ = 4'd9,     S_JAL = 4'd10,    S_LUI = 4'd11;
    localparam logic [3:0] S_TRAP = 4'd12,  S_JALR = 4'd13,   S_JALR_PC = 4'd14;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_JALR = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [2:0]  imm_src, alu_op;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [3:0]  state;
    logic        trap, timeout;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .imm_src(imm_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src), .state(state),
        .trap(trap), .timeout(timeout)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       mreq, mwr, adr, irw, pcw, rw;
        logic [2:0] imm;
        logic [1:0] a, b;
        logic [2:0] op;
        logic [1:0] res;
        logic       trp, tout;
    } obs_t;

    obs_t obs;
    assign obs = {state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, imm_src,
                  alu_src_a, alu_src_b, alu_op, result_src, trap, timeout};

    int n_tests = 0;
    int n_fail  = 0;
    int max_wait = 0;

    obs_t pq[$];
    bit   pm[$];

    function automatic obs_t mk(logic [3:0] st, logic mreq, logic mwr, logic adr, logic irw,
                                logic pcw, logic rw, logic [2:0] imm, logic [1:0] a,
                                logic [1:0] b, logic [2:0] op, logic [1:0] res, logic trp);
        obs_t o;
        o.st = st; o.mreq = mreq; o.mwr = mwr; o.adr = adr; o.irw = irw; o.pcw = pcw;
        o.rw = rw; o.imm = imm; o.a = a; o.b = b; o.op = op; o.res = res;
        o.trp = trp; o.tout = N;
        return o;
    endfunction

    function automatic void push(obs_t o, bit m);
        pq.push_back(o);
        pm.push_back(m);
    endfunction

    // Expected cycle-by-cycle phases of one instruction with zero-wait memory.
    function automatic void plan(logic [31:0] in, logic z);
        logic [6:0] opc;
        opc = in[6:0];
        pq.delete();
        pm.delete();
        push(mk(S_FETCH, Y,N,N,Y,Y,N, 3'd0, 2'd0, 2'd2, 3'd0, 2'd2, N), 1'b1);
        push(mk(S_DECODE, N,N,N,N,N,N, (opc == OP_JAL) ? 3'd3 : 3'd2, 2'd1, 2'd1, 3'd0, 2'd0, N), 1'b0);
        case (opc)
            OP_LOAD: begin
                push(mk(S_MEMADR, N,N,N,N,N,N, 3'd0, 2'd2, 2'd1, 3'd0, 2'd0, N), 1'b0);
                push(mk(S_MEMREAD, Y,N,Y,N,N,N, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, N), 1'b1);
                push(mk(S_MEMWB, N,N,N,N,N,Y, 3'd0, 2'd0, 2'd0, 3'd0, 2'd1, N), 1'b0);
            end
            OP_STORE: begin
                push(mk(S_MEMADR, N,N,N,N,N,N, 3'd1, 2'd2, 2'd1, 3'd0, 2'd0, N), 1'b0);
                push(mk(S_MEMWRITE, Y,Y,Y,N,N,N, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, N), 1'b1);
            end
            OP_R: begin
                push(mk(S_EXEC_R, N,N,N,N,N,N, 3'd0, 2'd2, 2'd0, 3'd2, 2'd0, N), 1'b0);
                push(mk(S_ALUWB, N,N,N,N,N,Y, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, N), 1'b0);
            end
            OP_I: begin
                push(mk(S_EXEC_I, N,N,N,N,N,N, 3'd0, 2'd2, 2'd1, 3'd3, 2'd0, N), 1'b0);
                push(mk(S_ALUWB, N,N,N,N,N,Y, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, N), 1'b0);
            end
            OP_BR:
                push(mk(S_BEQ, N,N,N,N,z,N, 3'd0, 2'd2, 2'd0, 3'd1, 2'd0, N), 1'b0);
            OP_JAL: begin
                push(mk(S_JAL, N,N,N,N,Y,N, 3'd0, 2'd1, 2'd2, 3'd0, 2'd0, N), 1'b0);
                push(mk(S_ALUWB, N,N,N,N,N,Y, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, N), 1'b0);
            end
            OP_LUI:
                push(mk(S_LUI, N,N,N,N,N,Y, 3'd4, 2'd0, 2'd0, 3'd0, 2'd3, N), 1'b0);
`ifdef MC_CTRL_JALR_EN
            OP_JALR: begin
                push(mk(S_JALR, N,N,N,N,N,N, 3'd0, 2'd2, 2'd1, 3'd0, 2'd0, N), 1'b0);
                push(mk(S_JALR_PC, N,N,N,N,Y,N, 3'd0, 2'd1, 2'd2, 3'd0, 2'd0, N), 1'b0);
                push(mk(S_ALUWB, N,N,N,N,N,Y, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, N), 1'b0);
            end
`endif
            default:
                push(mk(S_TRAP, N,N,N,N,N,N, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, Y), 1'b0);
        endcase
    endfunction

    task automatic check(input string tag, input obs_t exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are already set; sample mid-cycle, then advance past the next rising edge.
    task automatic cyc(input string tag, input obs_t exp);
        @(negedge clk);
        check(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] cur, input logic t, input logic to);
        obs_t e;
        e = mk(cur, N,N,N,N,N,N, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, t);
        e.tout = to;
        rst_n = 1'b0;
        mem_ready = 1'($urandom);
        cyc("reset_cycle", e);
        rst_n = 1'b1;
    endtask

    task automatic run_inst(input logic [31:0] in, input logic z, input int abort_at,
                            input int wait_at, input int wait_n);
        obs_t x, wt, tp;
        int   w;
        string tag;
        plan(in, z);
        inst = in;
        zero = z;
        for (int i = 0; i < pq.size(); i++) begin
            x   = pq[i];
            tag = $sformatf("inst%h_ph%0d_st%0d", in, i, x.st);
            if (i == abort_at) begin
                do_reset(x.st, N, N);
                return;
            end
            if (x.st == S_TRAP) begin
                for (int k = 0; k < 3; k++) begin
                    mem_ready = 1'($urandom);
                    cyc({tag, "_illegal_trap"}, x);
                end
                do_reset(S_TRAP, Y, N);
                return;
            end
            if (pm[i]) begin
                w  = (i == wait_at) ? wait_n : $urandom_range(0, max_wait);
                wt = x;
                wt.irw = N;
                wt.pcw = N;
                for (int k = 0; k < w && k < TO; k++) begin
                    mem_ready = 1'b0;
                    cyc({tag, "_wait"}, wt);
                end
                if (w >= TO) begin
                    tp = mk(S_TRAP, N,N,N,N,N,N, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, Y);
                    tp.tout = Y;
                    for (int k = 0; k < 3; k++) begin
                        mem_ready = 1'($urandom);
                        cyc({tag, "_timeout_trap"}, tp);
                    end
                    do_reset(S_TRAP, Y, Y);
                    return;
                end
                mem_ready = 1'b1;
                cyc({tag, "_done"}, x);
            end else begin
                mem_ready = 1'($urandom);
                cyc(tag, x);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0]  ops [8];
        logic [31:0] r;
        ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_LUI, OP_JALR};

        @(posedge clk);
        #1;
        do_reset(S_FETCH, N, N);

        max_wait = 0;
        run_inst(32'h00412083, 1'b0, -1, -1, 0);  // lw
        run_inst(32'h002081B3, 1'b0, -1, -1, 0);  // add
        run_inst(32'h00000063, 1'b1, -1, -1, 0);  // beq taken
        run_inst(32'h00000063, 1'b0, -1, -1, 0);  // beq not taken
        run_inst(32'h0020A223, 1'b0, -1, -1, 0);  // sw
        run_inst(32'h00108093, 1'b0, -1, -1, 0);  // addi
        run_inst(32'h0080006F, 1'b0, -1, -1, 0);  // jal
        run_inst(32'h123452B7, 1'b0, -1, -1, 0);  // lui
        run_inst(32'hFFFFFFFF, 1'b0, -1, -1, 0);  // illegal
        run_inst(32'h000100E7, 1'b0, -1, -1, 0);  // jalr

        // Timeout boundary in fetch and in the data phases.
        run_inst(32'h002081B3, 1'b0, -1, 0, TO);
        run_inst(32'h002081B3, 1'b0, -1, 0, TO - 1);
        run_inst(32'h00412083, 1'b0, -1, 3, TO);
        run_inst(32'h0020A223, 1'b0, -1, 3, TO - 1);
        run_inst(32'h0020A223, 1'b0, -1, 3, TO);

        // Reset while a load is waiting on memory.
        run_inst(32'h00412083, 1'b0, 3, -1, 0);
        run_inst(32'h002081B3, 1'b0, -1, -1, 0);

        max_wait = TO - 1;
        for (int n = 0; n < 60; n++) begin
            r = $urandom;
            if ($urandom_range(0, 4) != 0)
                r[6:0] = ops[$urandom_range(0, 7)];
            run_inst(r, 1'($urandom), -1, -1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
